// File: rtl/scan_pkg.sv
// Shared constants and digit-select helper for the multiplexed 8-digit hex display scanner.
package scan_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int NIBBLE_W   = 4;
    localparam int CNT_W      = 3;
    localparam int DATA_W     = 32;

    typedef logic [CNT_W-1:0]    digit_idx_t;
    typedef logic [NIBBLE_W-1:0] nibble_t;
    typedef logic [DATA_W-1:0]   disp_word_t;

    // Digit 0 is the leftmost digit, i.e. the most significant nibble.
    function automatic nibble_t digit_of(input disp_word_t d, input digit_idx_t idx);
        digit_idx_t pos;
        disp_word_t shifted;
        pos     = digit_idx_t'(NUM_DIGITS - 1) - idx;
        shifted = d >> (NIBBLE_W * int'(pos));
        return shifted[NIBBLE_W-1:0];
    endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Digit-slot prescaler: counts 0..DIV-1 while enabled and flags the last count as tick.
module refresh_prescaler #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // With DIV=1 LAST is zero, so tick follows en every cycle.
    assign tick = en && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Tear-free 8-digit display scanner: a new value waits in a one-deep pending buffer
// and is committed to the displayed word only at a frame boundary.
module display_scanner
    import scan_pkg::*;
#(
    parameter int DIV = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                upd_valid,
    input  logic [DATA_W-1:0]   upd_data,
    output logic                upd_ready,
    input  logic                hold,
    output logic [CNT_W-1:0]    count,
    output logic [NIBBLE_W-1:0] x,
    output logic                frame_done
);

    logic       tick;
    logic       frame_end;
    disp_word_t disp;
    disp_word_t pending;
    logic       pending_full;

    refresh_prescaler #(.DIV(DIV)) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (~hold),
        .tick (tick)
    );

    // tick already includes !hold, so a held scan can neither advance nor commit.
    assign frame_end = tick && (count == digit_idx_t'(NUM_DIGITS - 1));

    // NOTE: disp and pending are datapath registers but are reset anyway, because a
    // reset must blank the display and discard any value still waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            disp         <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            if (tick) begin
                count <= count + 1'b1;
            end
            frame_done <= frame_end;
            // Commit needs a full buffer and capture needs an empty one, so they never collide.
            if (frame_end && pending_full) begin
                disp         <= pending;
                pending_full <= 1'b0;
            end else if (upd_valid && !pending_full) begin
                pending      <= upd_data;
                pending_full <= 1'b1;
            end
        end
    end

    assign upd_ready = ~pending_full;
    assign x         = digit_of(disp, count);

endmodule
